// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the 16-bit arithmetic unit: parses the UART byte stream,
// drives operands/function/enable, and returns a 3-byte result/status response.
module alu_cmd_ctrl #(
  parameter int         OPER_WIDTH = 16,
  parameter logic [7:0] CMD_OPER   = 8'hCC,
  parameter logic [7:0] CMD_REUSE  = 8'hDD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_READY,
  output logic [OPER_WIDTH-1:0] ALU_A,
  output logic [OPER_WIDTH-1:0] ALU_B,
  output logic [1:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OPER_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_CARRY,
  input  logic                  ALU_FLAG
);

  localparam logic [1:0] FUN_DIV = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_A_LO, S_A_HI, S_B_LO, S_B_HI, S_FUN,
    S_EXEC, S_WAIT_RES, S_TX_LO, S_TX_HI, S_TX_ST
  } state_t;

  state_t                  state_q, state_d;
  logic [OPER_WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]              fun_q, fun_d;
  logic [7:0]              stat_q, stat_d;
  logic                    div_zero;

  // Divide by zero is resolved locally; the arithmetic unit is never enabled for it.
  assign div_zero = (RX_P_DATA[1:0] == FUN_DIV) && (b_q == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      res_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD && RX_P_DATA == CMD_OPER)       state_d = S_A_LO;
        else if (RX_D_VLD && RX_P_DATA == CMD_REUSE) state_d = S_FUN;
      end
      S_A_LO:     if (RX_D_VLD) state_d = S_A_HI;
      S_A_HI:     if (RX_D_VLD) state_d = S_B_LO;
      S_B_LO:     if (RX_D_VLD) state_d = S_B_HI;
      S_B_HI:     if (RX_D_VLD) state_d = S_FUN;
      S_FUN:      if (RX_D_VLD) state_d = div_zero ? S_TX_LO : S_EXEC;
      S_EXEC:     state_d = S_WAIT_RES;
      S_WAIT_RES: if (ALU_FLAG) state_d = S_TX_LO;
      S_TX_LO:    if (TX_READY) state_d = S_TX_HI;
      S_TX_HI:    if (TX_READY) state_d = S_TX_ST;
      S_TX_ST:    if (TX_READY) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Operand, function and response registers; operands persist across frames for reuse.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    fun_d  = fun_q;
    res_d  = res_q;
    stat_d = stat_q;
    case (state_q)
      S_A_LO: if (RX_D_VLD) a_d[7:0]            = RX_P_DATA;
      S_A_HI: if (RX_D_VLD) a_d[OPER_WIDTH-1:8] = RX_P_DATA;
      S_B_LO: if (RX_D_VLD) b_d[7:0]            = RX_P_DATA;
      S_B_HI: if (RX_D_VLD) b_d[OPER_WIDTH-1:8] = RX_P_DATA;
      S_FUN: begin
        if (RX_D_VLD) begin
          fun_d = RX_P_DATA[1:0];
          if (div_zero) begin
            res_d  = '0;
            stat_d = 8'h02;
          end
        end
      end
      S_WAIT_RES: begin
        if (ALU_FLAG) begin
          res_d  = ALU_OUT;
          stat_d = {7'b0, ALU_CARRY};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ALU_A     = a_q;
    ALU_B     = b_q;
    ALU_FUN   = fun_q;
    ALU_EN    = (state_q == S_EXEC);
    TX_D_VLD  = 1'b0;
    TX_P_DATA = 8'h00;
    case (state_q)
      S_TX_LO: begin TX_D_VLD = 1'b1; TX_P_DATA = res_q[7:0];            end
      S_TX_HI: begin TX_D_VLD = 1'b1; TX_P_DATA = res_q[OPER_WIDTH-1:8]; end
      S_TX_ST: begin TX_D_VLD = 1'b1; TX_P_DATA = stat_q;                end
      default: ;
    endcase
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller for the 16-bit arithmetic unit in the ALU block of the multi-clock system. Parses an 8-bit command/operand byte stream from the UART receive path, loads operands and function code into the arithmetic unit, pulses its enable, captures the registered result, and returns a 3-byte response to the UART transmit path over a valid/ready handshake. It is the initiator to the arithmetic unit's responder and runs entirely in the ALU clock domain.

## Interface
- OPER_WIDTH, 16, operand/result width; fixed at 16 (two bytes per operand)
- CMD_OPER, 8'hCC, command: load new A, B, then function
- CMD_REUSE, 8'hDD, command: reuse stored A, B, load function only
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous assert, active-low
- RX_P_DATA  in  8  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- TX_P_DATA  out  8  response byte
- TX_D_VLD  out  1  response byte valid
- TX_READY  in  1  transmitter accepts byte when TX_D_VLD & TX_READY at a rising edge
- ALU_A, ALU_B  out  16  operands to arithmetic unit
- ALU_FUN  out  2  00 add, 01 sub, 10 mul, 11 div
- ALU_EN  out  1  arithmetic enable, exactly one cycle per operation
- ALU_OUT  in  16  registered result
- ALU_CARRY  in  1  registered result bit 16
- ALU_FLAG  in  1  registered result valid

## Operation
- States: IDLE, A_LO, A_HI, B_LO, B_HI, FUN, EXEC, WAIT_RES, TX_LO, TX_HI, TX_ST.
- IDLE: on RX_D_VLD, byte==CMD_OPER -> A_LO; byte==CMD_REUSE -> FUN; any other byte dropped, stay IDLE.
- A_LO/A_HI/B_LO/B_HI: on RX_D_VLD latch byte into ALU_A[7:0]/[15:8], ALU_B[7:0]/[15:8]; advance. Little-endian.
- FUN: on RX_D_VLD latch RX_P_DATA[1:0] into ALU_FUN (bits 7:2 ignored). If function==11 and ALU_B==0 -> load result 0x0000, status 0x02, go TX_LO (ALU not enabled). Else -> EXEC.
- EXEC: ALU_EN=1 for this cycle only -> WAIT_RES.
- WAIT_RES: when ALU_FLAG=1, capture ALU_OUT and status={6'b0,1'b0,ALU_CARRY} -> TX_LO; else hold.
- TX_LO/TX_HI/TX_ST: TX_D_VLD=1, TX_P_DATA = result[7:0] / result[15:8] / status; advance on TX_READY; TX_ST -> IDLE.
- Status byte: bit0 carry (result bit 16), bit1 divide-by-zero, bits 7:2 zero.
- RX_D_VLD outside IDLE..FUN states: byte dropped, no state effect.
- ALU_A/ALU_B hold value between commands (required for CMD_REUSE); only CMD_OPER frames update them.
- All outputs Moore-decoded from state and held registers; no combinational path from any input to any output.

## Timing
- Reset (RST low, immediate): state IDLE; ALU_A=ALU_B=0, ALU_FUN=00, ALU_EN=0, TX_D_VLD=0, TX_P_DATA=0x00, result/status regs 0. Reset mid-frame or mid-response aborts it; no partial bytes after release.
- FUN byte accepted at edge k: ALU_EN high cycle k..k+1; ALU_FLAG seen in WAIT_RES cycle k+1..k+2; TX_D_VLD high from edge k+2.
- Divide-by-zero: TX_D_VLD high from edge k+1; ALU_EN never asserted.
- TX_D_VLD and TX_P_DATA stable while TX_READY low; one byte per accepting edge; back-to-back when TX_READY held high (response spans 3 cycles minimum).
- Minimum frame-to-response: CMD_OPER frame 6 bytes; CMD_REUSE 2 bytes.

## Test plan
- CC 01 00 02 00 00 (1+2) -> ALU_EN one cycle, response 03 00 00.
- CC FF FF 01 00 00 (0xFFFF+1) -> response 00 00 01; then CC 05 00 07 00 01 (5-7) -> FE FF 01.
- CC 00 01 00 01 02 (0x100*0x100) -> 00 00 01; then DD 03 (reuse, divide) -> 01 00 00.
- CC 09 00 00 00 03 (divide by zero) -> ALU_EN stays 0, response 00 00 02; stray byte 0x55 in IDLE ignored.
- TX_READY low 5 cycles during TX_HI -> TX_P_DATA holds result[15:8], TX_D_VLD held, no byte lost or duplicated; RX bytes sent during response dropped.
- RST pulsed low after A_HI byte -> all outputs at reset values immediately; following CC frame processed normally with ALU_A rebuilt from new bytes.
